// File: rtl/cache_line_fill_ctrl_if.sv
// Memory-side request/response bus of the line fill controller.
// master: the controller issuing requests; slave: the shared memory port.
interface cache_line_fill_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdata_valid;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata, mem_rdata_valid
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata, mem_rdata_valid
    );
endinterface

// File: rtl/cache_line_fill_ctrl.sv
// Cache miss controller: optional dirty-victim write-back followed by a
// line fill (word 0 first, or critical word first with wrap), driving the
// data/tag arrays and a stallable memory request port.
module cache_line_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8,
    parameter int BYTE_W = 1,
    parameter int CWF    = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       miss_detected,
    input  logic [ADDR_W-1:0]          miss_addr,
    input  logic                       victim_dirty,
    input  logic [ADDR_W-1:0]          victim_addr,
    output logic [$clog2(WORDS)-1:0]   cache_rd_idx,
    input  logic [DATA_W-1:0]          cache_rd_data,
    output logic                       data_we,
    output logic [$clog2(WORDS)-1:0]   data_idx,
    output logic [DATA_W-1:0]          data_wdata,
    output logic                       tag_we,
    output logic                       busy,
    output logic                       done,
    cache_line_fill_ctrl_if.master     mem
);
    localparam int OFF_W  = $clog2(WORDS);
    localparam int CNT_W  = OFF_W + 1;
    localparam int LINE_W = ADDR_W - OFF_W - BYTE_W;

    localparam logic [CNT_W-1:0] CNT_WORDS = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] victim_q;
    logic [OFF_W-1:0]  start_q;
    logic [CNT_W-1:0]  wb_cnt;
    logic [CNT_W-1:0]  iss_cnt;
    logic [CNT_W-1:0]  ret_cnt;

    logic [OFF_W-1:0]  miss_off;
    logic [OFF_W-1:0]  iss_idx;
    logic [OFF_W-1:0]  ret_idx;
    logic              wb_acc;
    logic              iss_pending;
    logic              rd_acc;
    logic              ret_ok;

    // Byte-offset and word-offset bits of the addresses are not stored.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{miss_addr[OFF_W+BYTE_W-1:0], victim_addr[OFF_W+BYTE_W-1:0]};

    // Fill sequence indices wrap naturally in OFF_W bits.
    assign miss_off    = (CWF != 0) ? miss_addr[OFF_W+BYTE_W-1:BYTE_W] : '0;
    assign iss_idx     = start_q + iss_cnt[OFF_W-1:0];
    assign ret_idx     = start_q + ret_cnt[OFF_W-1:0];
    assign wb_acc      = (state == S_WB) && mem.mem_ready;
    assign iss_pending = (state == S_FILL) && (iss_cnt < CNT_WORDS);
    assign rd_acc      = iss_pending && mem.mem_ready;
    assign ret_ok      = (state == S_FILL) && mem.mem_rdata_valid && (ret_cnt < CNT_WORDS);

    // State, miss capture and the three independent word counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            line_q   <= '0;
            victim_q <= '0;
            start_q  <= '0;
            wb_cnt   <= '0;
            iss_cnt  <= '0;
            ret_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss_detected) begin
                        line_q   <= miss_addr[ADDR_W-1:OFF_W+BYTE_W];
                        victim_q <= victim_addr[ADDR_W-1:OFF_W+BYTE_W];
                        start_q  <= miss_off;
                        wb_cnt   <= '0;
                        iss_cnt  <= '0;
                        ret_cnt  <= '0;
                        state    <= victim_dirty ? S_WB : S_FILL;
                    end
                end
                S_WB: begin
                    if (wb_acc) begin
                        wb_cnt <= wb_cnt + CNT_ONE;
                        if (wb_cnt == CNT_LAST) begin
                            state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (rd_acc) begin
                        iss_cnt <= iss_cnt + CNT_ONE;
                    end
                    if (ret_ok) begin
                        ret_cnt <= ret_cnt + CNT_ONE;
                        if (ret_cnt == CNT_LAST) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Per-state outputs; everything not active in a state is driven low.
    always_comb begin
        cache_rd_idx  = '0;
        data_we       = 1'b0;
        data_idx      = '0;
        data_wdata    = '0;
        tag_we        = 1'b0;
        done          = 1'b0;
        busy          = (state != S_IDLE);
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        case (state)
            S_WB: begin
                cache_rd_idx  = wb_cnt[OFF_W-1:0];
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = {victim_q, wb_cnt[OFF_W-1:0], {BYTE_W{1'b0}}};
                mem.mem_wdata = cache_rd_data;
            end
            S_FILL: begin
                if (iss_pending) begin
                    mem.mem_req  = 1'b1;
                    mem.mem_addr = {line_q, iss_idx, {BYTE_W{1'b0}}};
                end
                if (ret_ok) begin
                    data_we    = 1'b1;
                    data_idx   = ret_idx;
                    data_wdata = mem.mem_rdata;
                end
            end
            S_DONE: begin
                tag_we = 1'b1;
                done   = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule
